// File: rtl/audio_sample_player.sv
// audio_sample_player
//   Streams unsigned 8-bit audio samples from a synchronous ROM at a fixed
//   sample rate, applies volume scaling and drives the pwm stage.
//   Supports start/stop/pause, loop or one-shot playback and an end-of-song
//   done pulse.
// Ports
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   start      : 1-cycle pulse, (re)start playback at address 0
//   stop       : 1-cycle pulse, abort playback and go silent
//   pause      : level, freeze playback while high
//   loop_en    : 1 = wrap to address 0 at end of song, 0 = one-shot
//   volume     : gain = (volume+1)/16, sampled at each sample tick
//   rom_addr   : ROM address (registered)
//   rom_data   : ROM data, valid one cycle after rom_addr changes
//   audio_data : sample to pwm, 128 = silence (registered)
//   playing    : high while playing or draining the last sample (registered)
//   done       : 1-cycle pulse at the natural end of a one-shot song
module audio_sample_player #(
    parameter int unsigned SAMPLE_DIV = 12500,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned SONG_LEN   = 40000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [3:0]        volume,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        audio_data,
    output logic              playing,
    output logic              done
);

    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
    localparam logic [7:0]        SILENCE   = 8'd128;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [7:0]        audio_q, audio_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;

    logic              tick;
    logic signed [8:0] centred;
    logic signed [5:0] gain;
    logic signed [13:0] product;
    logic signed [13:0] shifted;
    logic [7:0]        scaled;

    assign tick = (div_cnt_q == CNT_LAST);

    // Signed product of the centred sample and (volume+1); the arithmetic
    // shift floors, and the result always lies in -128..127 so the low byte
    // plus 128 is the exact unsigned output.
    always_comb begin
        centred = $signed({1'b0, rom_data}) - 9'sd128;
        gain    = $signed({2'b00, volume}) + 6'sd1;
        product = 14'(centred) * 14'(gain);
        shifted = product >>> 4;
        scaled  = shifted[7:0] + 8'd128;
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        div_cnt_d  = div_cnt_q;
        audio_d    = audio_q;
        done_d     = 1'b0;

        if (stop) begin
            state_d    = ST_IDLE;
            rom_addr_d = '0;
            div_cnt_d  = '0;
            audio_d    = SILENCE;
        end else if (start) begin
            // audio_data keeps its value until the first tick of the restart
            state_d    = ST_PLAY;
            rom_addr_d = '0;
            div_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    audio_d = SILENCE;
                end
                ST_PLAY: begin
                    if (!pause) begin
                        if (tick) begin
                            div_cnt_d = '0;
                            audio_d   = scaled;
                            if (rom_addr_q != ADDR_LAST) begin
                                rom_addr_d = rom_addr_q + 1'b1;
                            end else if (loop_en) begin
                                rom_addr_d = '0;
                            end else begin
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            div_cnt_d = div_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!pause) begin
                        if (tick) begin
                            state_d    = ST_IDLE;
                            div_cnt_d  = '0;
                            rom_addr_d = '0;
                            audio_d    = SILENCE;
                            done_d     = 1'b1;
                        end else begin
                            div_cnt_d = div_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    rom_addr_d = '0;
                    div_cnt_d  = '0;
                    audio_d    = SILENCE;
                end
            endcase
        end

        playing_d = (state_d == ST_PLAY) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            div_cnt_q  <= '0;
            audio_q    <= SILENCE;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            div_cnt_q  <= div_cnt_d;
            audio_q    <= audio_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign audio_data = audio_q;
    assign playing    = playing_q;
    assign done       = done_q;

endmodule
